instruction_fetch_unit: RTL and testbench

//  Fetch/decode front end. Drives PC into the 16-bit instruction BRAM (1-cycle read latency).

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/program_counter.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, instruction field layout, widths.
package cpu_pkg;

    localparam int unsigned PC_W    = 15;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_A_W = 4;
    localparam int unsigned OP_W    = 4;

    // Instruction field positions (LSB of each 4-bit field)
    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RS_LSB = 8;
    localparam int unsigned RT_LSB = 4;
    localparam int unsigned RD_LSB = 0;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        CAPT   = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } fetchState_t;

    // Instruction word viewed as its four fields, MSB first
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [REG_A_W-1:0] rs;
        logic [REG_A_W-1:0] rt;
        logic [REG_A_W-1:0] rd;
    } instrFields_t;

    // Extract a register-address field starting at bit lsb
    function automatic logic [REG_A_W-1:0] regField(input logic [INSTR_W-1:0] word,
                                                    input int unsigned lsb);
        return word[lsb +: REG_A_W];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: async reset, redirect load with priority, wrapping increment.
module program_counter
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 15'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] loadPc,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // Load beats increment; natural 15-bit overflow gives the wrap to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= loadPc;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch/decode front end: PC -> BRAM -> IR -> field decode, one instruction in flight.
// Optional build macro FETCH_STALL_COUNT_EN adds a saturating stall_count output.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 15'h0000,
    parameter logic [OP_W-1:0] HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    mem_addr,
    output logic               mem_en,
    input  logic [INSTR_W-1:0] mem_dout,
    output logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    opcode,
    output logic [REG_A_W-1:0] rs_addr,
    output logic [REG_A_W-1:0] rt_addr,
    output logic [REG_A_W-1:0] rd_addr,
    output logic               reg_read,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    fetchState_t        stateQ;
    fetchState_t        stateNext;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    memAddrQ;
    logic [PC_W-1:0]    instrPcQ;
    logic [INSTR_W-1:0] irQ;
    logic               capture;
    logic               pcInc;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) pcReg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (redirect_valid),
        .loadPc (redirect_pc),
        .inc    (pcInc),
        .pc     (pc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= REQ;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next state and strobes; redirect overrides every transition.
    // mem_en is qualified by rst_n so no read is requested while reset is held.
    always_comb begin
        stateNext   = stateQ;
        mem_en      = 1'b0;
        instr_valid = 1'b0;
        reg_read    = 1'b0;
        halted      = 1'b0;
        capture     = 1'b0;
        pcInc       = 1'b0;
        case (stateQ)
            REQ: begin
                mem_en    = rst_n;
                stateNext = CAPT;
            end
            CAPT: begin
                capture   = !redirect_valid;
                pcInc     = 1'b1;
                stateNext = VALID;
            end
            VALID: begin
                instr_valid = 1'b1;
                reg_read    = 1'b1;
                if (instr_ready) begin
                    stateNext = (opcode == HALT_OP) ? HALTED : REQ;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                stateNext = REQ;
            end
        endcase
        if (redirect_valid) begin
            stateNext = REQ;
        end
    end

    // IR capture, fetch-address record and held BRAM address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irQ      <= '0;
            instrPcQ <= '0;
            memAddrQ <= RESET_PC;
        end else begin
            if (stateQ == REQ) begin
                memAddrQ <= pc;
            end
            if (capture) begin
                irQ      <= mem_dout;
                instrPcQ <= pc;
            end
        end
    end

    // Address follows pc while requesting, otherwise holds the last one driven
    assign mem_addr = (stateQ == REQ) ? pc : memAddrQ;
    assign instr    = irQ;
    assign instr_pc = instrPcQ;
    assign opcode   = irQ[OP_LSB +: OP_W];
    assign rs_addr  = regField(irQ, RS_LSB);
    assign rt_addr  = regField(irQ, RT_LSB);
    assign rd_addr  = regField(irQ, RD_LSB);

`ifdef FETCH_STALL_COUNT_EN
    // Saturating count of cycles the consumer leaves a valid IR waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if ((stateQ == VALID) && !instr_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a 1-cycle-latency BRAM model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [14:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_dout;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [3:0]  rd_addr;
    logic        reg_read;
    logic [14:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [14:0] redirect_pc;
    logic        halted;
`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [14:0] pc;
        logic [3:0]  op;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t popped;

    logic [15:0] mem [0:32767];

    instruction_fetch_unit #(
        .RESET_PC (15'h0002),
        .HALT_OP  (4'hF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .mem_dout       (mem_dout),
        .instr          (instr),
        .opcode         (opcode),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rd_addr        (rd_addr),
        .reg_read       (reg_read),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM: registered read, enable-gated
    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [15:0] i, input logic [14:0] p,
                           input logic [3:0] op, input logic [3:0] rs,
                           input logic [3:0] rt, input logic [3:0] rd);
        exp_t e;
        e.instr = i; e.pc = p; e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            tick(1);
            n++;
        end
        check("valid_within_budget", 32'(instr_valid), 32'd1);
    endtask

    task automatic handshake();
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
    endtask

    // Monitor: every accepted instruction is compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handshake: got instr 0x%0h, expected none", instr);
            end else begin
                popped = sb.pop_front();
                check("hs_instr",    32'(instr),    32'(popped.instr));
                check("hs_instr_pc", 32'(instr_pc), 32'(popped.pc));
                check("hs_fields",   32'({opcode, rs_addr, rt_addr, rd_addr}),
                      32'({popped.op, popped.rs, popped.rt, popped.rd}));
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[2]     = 16'h2010;
        mem[3]     = 16'h1234;
        mem[4]     = 16'hABCD;
        mem[32767] = 16'h5678;
        mem[0]     = 16'hF000;
        mem_dout       = 16'h0000;
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 15'h0000;

        // Reset values
        tick(3);
        check("rst_mem_addr",    32'(mem_addr),    32'h2);
        check("rst_mem_en",      32'(mem_en),      32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_outputs",     32'({instr, instr_pc, reg_read, halted}), 32'd0);

        // First fetch from RESET_PC, two clocks to valid
        rst_n = 1'b1;
        @(negedge clk);
        check("req_mem_en",   32'(mem_en),   32'd1);
        check("req_mem_addr", 32'(mem_addr), 32'h2);
        tick(1);
        check("capt_not_valid", 32'(instr_valid), 32'd0);
        tick(1);
        check("latency_valid", 32'(instr_valid), 32'd1);
        check("first_instr",   32'(instr),       32'h2010);
        check("first_fields",  32'({opcode, rs_addr, rt_addr}), 32'h201);
        check("first_pc",      32'(instr_pc),    32'h2);
        pushExp(16'h2010, 15'h2, 4'h2, 4'h0, 4'h1, 4'h0);

        // Stall five clocks: IR held
        tick(5);
        check("stall_instr",    32'(instr),       32'h2010);
        check("stall_fields",   32'({opcode, rs_addr, rt_addr, rd_addr}), 32'h2010);
        check("stall_reg_read", 32'(reg_read),    32'd1);
        check("stall_valid",    32'(instr_valid), 32'd1);
`ifdef FETCH_STALL_COUNT_EN
        check("stall_count", 32'(stall_count), 32'd5);
`endif
        handshake();

        // Sequential fetch from 3
        @(negedge clk);
        check("seq_mem_addr", 32'(mem_addr), 32'h3);
        pushExp(16'h1234, 15'h3, 4'h1, 4'h2, 4'h3, 4'h4);
        tick(1);
        waitValid(5);
        check("seq_rs_rt", 32'({rs_addr, rt_addr}), 32'h23);
        handshake();

        // Redirect during CAPT: word from 4 dropped, IR keeps old value
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc    = 15'h7FFF;
        tick(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_mem_addr",  32'(mem_addr),    32'h7FFF);
        check("redir_ir_kept",   32'(instr),       32'h1234);
        check("redir_not_valid", 32'(instr_valid), 32'd0);
        pushExp(16'h5678, 15'h7FFF, 4'h5, 4'h6, 4'h7, 4'h8);
        tick(1);
        waitValid(5);
        handshake();

        // PC wrap: next fetch from 0 returns the halt word
        @(negedge clk);
        check("wrap_mem_addr", 32'(mem_addr), 32'h0);
        pushExp(16'hF000, 15'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        tick(1);
        waitValid(5);
        handshake();

        // Parked in HALTED for ten clocks
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_state", 32'({halted, mem_en, instr_valid}), 32'b100);
            tick(1);
        end
        check("halt_mem_addr_held", 32'(mem_addr), 32'h0);

        // Redirect out of HALTED to 2
        redirect_valid = 1'b1;
        redirect_pc    = 15'h0002;
        tick(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("unhalt_halted",   32'(halted),   32'd0);
        check("unhalt_mem_addr", 32'(mem_addr), 32'h2);
        pushExp(16'h2010, 15'h2, 4'h2, 4'h0, 4'h1, 4'h0);
        tick(1);
        waitValid(5);
        handshake();

        // Reset while VALID holds 16'h1234
        waitValid(5);
        check("pre_reset_instr", 32'(instr), 32'h1234);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",   32'({instr_valid, reg_read, mem_en, halted}), 32'd0);
        check("async_rst_ir",      32'({instr, opcode, rs_addr, rt_addr, rd_addr}), 32'd0);
        check("async_rst_pc",      32'(instr_pc), 32'd0);
        check("async_rst_memaddr", 32'(mem_addr), 32'h2);
`ifdef FETCH_STALL_COUNT_EN
        check("async_rst_stall", 32'(stall_count), 32'd0);
`endif
        tick(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_mem", 32'({mem_en, mem_addr}), 32'({1'b1, 15'h2}));
        pushExp(16'h2010, 15'h2, 4'h2, 4'h0, 4'h1, 4'h0);
        tick(1);
        waitValid(5);
        handshake();

        tick(2);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
